// File: rtl/sync_debounce.sv
// sync_debounce: synchronise a raw async level into clk,
// then debounce it into a clean level plus rise/fall pulses.
module sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_raw,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE =
    CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_d_s;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_q;
  logic                   w_q_nxt;
  logic                   r_rise;
  logic                   w_rise_nxt;
  logic                   r_fall;
  logic                   w_fall_nxt;

  // Plain shift chain: nothing between the metastability flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d_raw};
    end
  end

  assign w_d_s = r_sync[SYNC_STAGES-1];

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_q     <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Qualify a candidate level; any opposite sample aborts it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    unique case (r_state)
      IDLE_LOW: begin
        if (w_d_s) begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = LP_CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!w_d_s) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_CNT_MAX) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
          w_q_nxt     = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + LP_CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!w_d_s) begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = LP_CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (w_d_s) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_CNT_MAX) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
          w_q_nxt     = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + LP_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
        w_cnt_nxt   = '0;
        w_q_nxt     = 1'b0;
      end
    endcase
  end

  assign q    = r_q;
  assign rise = r_rise;
  assign fall = r_fall;
  assign busy = (r_state == WAIT_HIGH) ||
                (r_state == WAIT_LOW);

endmodule
